// File: rtl/adsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_pkg
//  Purpose  : Shared state encoding and envelope full-scale helper for the
//             ADSR amplitude envelope stage.
//  Revision : 1.0  initial release
// ============================================================================
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  // Full-scale envelope level for a given envelope width (2^envsize - 1).
  function automatic logic [31:0] env_max(input int unsigned envsize);
    return (32'd1 << envsize) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/env_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : env_scaler
//  Purpose  : Two-stage signed sample x unsigned envelope multiply, floored
//             right shift by ENVSIZE back to sample width.
//  Revision : 1.0  initial release
// ============================================================================
module env_scaler #(
  parameter int BITSIZE = 24,
  parameter int ENVSIZE = 16
) (
  input  logic               lrclk,
  input  logic               resetn,
  input  logic [BITSIZE-1:0] i_sample,
  input  logic [ENVSIZE-1:0] i_env,
  output logic [BITSIZE-1:0] o_sample
);

  localparam int c_PW = BITSIZE + ENVSIZE + 1;

  logic        [BITSIZE-1:0] r_sample;
  logic        [ENVSIZE-1:0] r_env;
  logic        [BITSIZE-1:0] r_out;
  logic signed [c_PW-1:0]    w_sample_ext;
  logic signed [c_PW-1:0]    w_env_ext;
  logic signed [c_PW-1:0]    w_prod;
  logic                      w_unused_prod;

  // Both operands are widened to the full product width so the low bits of
  // the multiply are exact; the envelope is zero-extended to stay positive.
  assign w_sample_ext = {{(ENVSIZE+1){r_sample[BITSIZE-1]}}, r_sample};
  assign w_env_ext    = {{BITSIZE{1'b0}}, 1'b0, r_env};
  assign w_prod       = w_sample_ext * w_env_ext;

  // Magnitude of the product never exceeds the input, so the sign bit above
  // the kept slice is redundant; the dropped low bits give floor rounding.
  assign w_unused_prod = ^{w_prod[c_PW-1], w_prod[ENVSIZE-1:0]};

  always_ff @(posedge lrclk or negedge resetn) begin
    if (!resetn) begin
      r_sample <= '0;
      r_env    <= '0;
      r_out    <= '0;
    end else begin
      r_sample <= i_sample;
      r_env    <= i_env;
      r_out    <= w_prod[ENVSIZE +: BITSIZE];
    end
  end

  assign o_sample = r_out;

endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_envelope
//  Purpose  : Gate-driven attack/decay/sustain/release envelope generator that
//             scales the incoming sine sample by the current envelope level.
//  Revision : 1.0  initial release
// ============================================================================
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int ENVSIZE = 16
) (
  input  logic               lrclk,
  input  logic               resetn,
  input  logic               gate,
  input  logic [ENVSIZE-1:0] attack_rate,
  input  logic [ENVSIZE-1:0] decay_rate,
  input  logic [ENVSIZE-1:0] sustain_level,
  input  logic [ENVSIZE-1:0] release_rate,
  input  logic [BITSIZE-1:0] in,
  output logic [BITSIZE-1:0] out,
  output logic [ENVSIZE-1:0] env,
  output logic               active
);

  localparam logic [ENVSIZE:0] c_ENV_MAX = (ENVSIZE+1)'(env_max(ENVSIZE));

  adsr_state_t        r_state;
  adsr_state_t        w_state_nxt;
  logic [ENVSIZE-1:0] r_env;
  logic [ENVSIZE-1:0] w_env_nxt;
  logic               r_gate_d;
  logic               w_rise;
  logic               w_held;
  logic [ENVSIZE:0]   w_att_sum;
  logic [ENVSIZE:0]   w_dec_lim;

  assign w_rise    = gate & ~r_gate_d;
  assign w_held    = (r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                     (r_state == ST_SUSTAIN);
  assign w_att_sum = {1'b0, r_env} + {1'b0, attack_rate};
  assign w_dec_lim = {1'b0, sustain_level} + {1'b0, decay_rate};

  always_ff @(posedge lrclk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_gate_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_gate_d <= gate;
    end
  end

  // A zero rate freezes both the level and the state in that segment.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_rise) begin
      w_state_nxt = ST_ATTACK;
    end else if (!gate && w_held) begin
      w_state_nxt = ST_RELEASE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_env_nxt = '0;
        end
        ST_ATTACK: begin
          if (attack_rate != '0) begin
            if (w_att_sum >= c_ENV_MAX) begin
              w_env_nxt   = c_ENV_MAX[ENVSIZE-1:0];
              w_state_nxt = ST_DECAY;
            end else begin
              w_env_nxt = w_att_sum[ENVSIZE-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (decay_rate != '0) begin
            if ({1'b0, r_env} <= w_dec_lim) begin
              w_env_nxt   = sustain_level;
              w_state_nxt = ST_SUSTAIN;
            end else begin
              w_env_nxt = r_env - decay_rate;
            end
          end
        end
        ST_SUSTAIN: begin
          w_env_nxt = sustain_level;
        end
        ST_RELEASE: begin
          if (release_rate != '0) begin
            if (r_env <= release_rate) begin
              w_env_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_env_nxt = r_env - release_rate;
            end
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign active = (r_state != ST_IDLE);
  assign env    = r_env;

  env_scaler #(
    .BITSIZE (BITSIZE),
    .ENVSIZE (ENVSIZE)
  ) u_env_scaler (
    .lrclk    (lrclk),
    .resetn   (resetn),
    .i_sample (in),
    .i_env    (r_env),
    .o_sample (out)
  );

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_envelope
//  Purpose  : Directed and randomized checks of adsr_envelope against an
//             integer reference model of the envelope and scaling rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adsr_envelope;

  localparam int BITSIZE = 24;
  localparam int ENVSIZE = 16;
  localparam int EMAX    = 65535;
  localparam int M_IDLE  = 0;
  localparam int M_ATK   = 1;
  localparam int M_DEC   = 2;
  localparam int M_SUS   = 3;
  localparam int M_REL   = 4;

  logic               lrclk = 1'b0;
  logic               resetn = 1'b0;
  logic               gate = 1'b0;
  logic [ENVSIZE-1:0] attack_rate = '0;
  logic [ENVSIZE-1:0] decay_rate = '0;
  logic [ENVSIZE-1:0] sustain_level = '0;
  logic [ENVSIZE-1:0] release_rate = '0;
  logic [BITSIZE-1:0] in_s = '0;
  logic [BITSIZE-1:0] out_s;
  logic [ENVSIZE-1:0] env;
  logic               active;

  always #5 lrclk = ~lrclk;

  adsr_envelope #(
    .BITSIZE (BITSIZE),
    .ENVSIZE (ENVSIZE)
  ) dut (
    .lrclk         (lrclk),
    .resetn        (resetn),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .in            (in_s),
    .out           (out_s),
    .env           (env),
    .active        (active)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     m_state;
  int     m_env;
  int     m_gd;
  int     m_s1_env;
  longint m_s1_in;
  longint m_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // floor(s * e / 2^ENVSIZE) with plain integer arithmetic
  function automatic longint scale(input longint s, input longint e);
    longint p;
    longint q;
    p = s * e;
    q = p / 65536;
    if (p < 0 && q * 65536 != p) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_env    = 0;
    m_gd     = 0;
    m_s1_in  = 0;
    m_s1_env = 0;
    m_out    = 0;
  endtask

  // Advances the model by one sample using the inputs about to be sampled.
  task automatic model_edge();
    int ne;
    int ns;
    int ar;
    int dr;
    int sl;
    int rr;
    ne = m_env;
    ns = m_state;
    ar = int'(attack_rate);
    dr = int'(decay_rate);
    sl = int'(sustain_level);
    rr = int'(release_rate);
    if (gate && m_gd == 0) begin
      ns = M_ATK;
    end else if (!gate && (m_state == M_ATK || m_state == M_DEC || m_state == M_SUS)) begin
      ns = M_REL;
    end else if (m_state == M_IDLE) begin
      ne = 0;
    end else if (m_state == M_ATK && ar != 0) begin
      ne = (m_env + ar >= EMAX) ? EMAX : m_env + ar;
      if (ne == EMAX) ns = M_DEC;
    end else if (m_state == M_DEC && dr != 0) begin
      if (m_env <= sl + dr) begin
        ne = sl;
        ns = M_SUS;
      end else begin
        ne = m_env - dr;
      end
    end else if (m_state == M_SUS) begin
      ne = sl;
    end else if (m_state == M_REL && rr != 0) begin
      if (m_env <= rr) begin
        ne = 0;
        ns = M_IDLE;
      end else begin
        ne = m_env - rr;
      end
    end
    m_out    = scale(m_s1_in, longint'(m_s1_env));
    m_s1_in  = longint'($signed(in_s));
    m_s1_env = m_env;
    m_env    = ne;
    m_state  = ns;
    m_gd     = int'(gate);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".env"}, 64'(env), 64'(m_env));
    check({tag, ".active"}, 64'(active), 64'(m_state != M_IDLE));
    check({tag, ".out"}, 64'(out_s), 64'(m_out & 64'hFFFFFF));
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge lrclk);
    @(negedge lrclk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    check({tag, ".env"}, 64'(env), 64'd0);
    check({tag, ".out"}, 64'(out_s), 64'd0);
    check({tag, ".active"}, 64'(active), 64'd0);
    model_reset();
    @(negedge lrclk);
    resetn = 1'b1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge lrclk);
    check_all("reset");
    resetn = 1'b1;
    cyc("idle");

    // attack from zero, saturate, decay to sustain, track sustain changes
    attack_rate   = 16'h1000;
    decay_rate    = 16'h4000;
    sustain_level = 16'h8000;
    release_rate  = 16'h2000;
    gate          = 1'b1;
    cyc("rise");
    repeat (15) cyc("atk");
    check("atk15", 64'(env), 64'h0F000);
    cyc("atk_sat");
    check("atk_sat", 64'(env), 64'h0FFFF);
    cyc("dec1");
    check("dec1", 64'(env), 64'h0BFFF);
    cyc("dec2");
    check("dec_sus", 64'(env), 64'h08000);
    sustain_level = 16'h6000;
    cyc("sus_track");
    check("sus_track", 64'(env), 64'h06000);

    // release then retrigger mid-release
    gate = 1'b0;
    cyc("rel0");
    cyc("rel1");
    check("rel1", 64'(env), 64'h04000);
    cyc("rel2");
    gate = 1'b1;
    cyc("retrig");
    check("retrig", 64'(env), 64'h02000);
    cyc("retrig_atk");
    check("retrig_atk", 64'(env), 64'h03000);

    // hold full scale in sustain and check scaling / latency
    sustain_level = 16'hFFFF;
    repeat (16) cyc("to_full");
    check("full", 64'(env), 64'h0FFFF);
    in_s = 24'h7FFFFF;
    cyc("sc_a");
    cyc("sc_a");
    check("scale_pos", 64'(out_s), 64'h7FFF7F);
    in_s = 24'h800000;
    cyc("sc_b");
    cyc("sc_b");
    check("scale_neg", 64'(out_s), 64'h800080);
    sustain_level = 16'h8000;
    cyc("half");
    in_s = 24'h000003;
    cyc("sc_c");
    cyc("sc_c");
    check("scale_p3", 64'(out_s), 64'h000001);
    in_s = 24'hFFFFFD;
    cyc("sc_d");
    cyc("sc_d");
    check("scale_floor", 64'(out_s), 64'hFFFFFE);

    // zero attack rate holds the level in ATTACK
    attack_rate = '0;
    gate = 1'b0;
    cyc("z_rel");
    gate = 1'b1;
    cyc("z_atk");
    repeat (5) cyc("z_hold");
    check("zero_hold", 64'(env), 64'h08000);
    gate = 1'b0;
    cyc("z_gate_lo");
    repeat (6) cyc("z_drain");
    check("drained", 64'(active), 64'd0);

    // asynchronous reset mid-attack
    attack_rate = 16'h1000;
    gate = 1'b1;
    repeat (4) cyc("pre_rst");
    check("pre_rst", 64'(env), 64'h03000);
    gate = 1'b0;
    do_reset("async_rst");
    repeat (3) cyc("post_rst");

    // randomized operation
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 24 == 0) gate = ~gate;
      if ($urandom % 40 == 0) begin
        attack_rate   = 16'($urandom_range(1, 16'h3000));
        decay_rate    = 16'($urandom_range(1, 16'h3000));
        release_rate  = 16'($urandom_range(1, 16'h3000));
        sustain_level = 16'($urandom_range(0, 16'hFFFF));
        if ($urandom % 4 == 0) attack_rate = 16'hFFFF;
        if ($urandom % 4 == 0) release_rate = 16'hFFFF;
      end
      if ($urandom % 30 == 0) sustain_level = 16'($urandom_range(0, 16'hFFFF));
      in_s = 24'($urandom);
      if ($urandom % 300 == 0) do_reset("rnd_rst");
      else cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Amplitude envelope stage placed directly downstream of the sine generator, clocked at the sample rate (lrclk).
- Runs an attack/decay/sustain/release state machine driven by a gate input.
- Produces an unsigned envelope level and multiplies each incoming signed sample by it.
- The scaled sample feeds the I2S output path.

Parameters:
BITSIZE, 24, width of signed audio sample in/out
ENVSIZE, 16, width of unsigned envelope level; full scale = 2^ENVSIZE-1

Ports:
lrclk  input  1  sample clock; every register updates on its rising edge
resetn  input  1  asynchronous active-low reset
gate  input  1  note on (1) / note off (0), sampled on lrclk
attack_rate  input  ENVSIZE  envelope increment per sample in ATTACK
decay_rate  input  ENVSIZE  envelope decrement per sample in DECAY
sustain_level  input  ENVSIZE  level held in SUSTAIN
release_rate  input  ENVSIZE  envelope decrement per sample in RELEASE
in  input  BITSIZE  signed sample from sine generator
out  output  BITSIZE  signed scaled sample
env  output  ENVSIZE  current envelope level
active  output  1  high whenever state != IDLE

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, env=0, out=0, active=0, gate_d=0, all pipeline registers 0. Release of reset is sampled on the next lrclk edge.
- gate_d is a registered copy of gate. Rising edge = gate & ~gate_d.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. One env update per lrclk.
- Rising edge of gate, in any state: next state ATTACK. env continues from its current value (no reset to 0). Retrigger has priority over every other transition.
- gate low while in ATTACK, DECAY or SUSTAIN: next state RELEASE; env is unchanged in that cycle.
- ATTACK: sum = env + attack_rate, computed ENVSIZE+1 wide.
  - If sum >= 2^ENVSIZE-1: env = 2^ENVSIZE-1, next state DECAY.
  - Otherwise env = sum.
- DECAY:
  - If env <= sustain_level + decay_rate (ENVSIZE+1 wide compare): env = sustain_level, next state SUSTAIN.
  - Otherwise env = env - decay_rate.
  - If sustain_level > env on entry, env = sustain_level and next state SUSTAIN.
- SUSTAIN: env = sustain_level every cycle, so it tracks live changes.
- RELEASE:
  - If env <= release_rate: env = 0, next state IDLE.
  - Otherwise env = env - release_rate.
- IDLE: env = 0.
- Rate of 0: env holds and the state machine stays put. This is legal, not an error.
- env never wraps in either direction; all clamping is saturating.
- Scaling, 2-stage pipeline:
  - Stage 1 registers in and env.
  - Stage 2 computes signed product in * {1'b0, env}, which is BITSIZE+ENVSIZE+1 wide, arithmetic-shifts it right by ENVSIZE and registers the result to out.
  - out at edge n+2 reflects the in and env values present at edge n.
  - Truncation floors toward negative infinity.
- active is combinational from the state register (state != IDLE). env output is the register itself.
- Deasserting resetn mid-note aborts immediately. After reset, out drains to 0 because the pipeline is cleared.

Decomposition:
- Shared package adsr_pkg:
  - state encoding constants ST_IDLE=0, ST_ATTACK=1, ST_DECAY=2, ST_SUSTAIN=3, ST_RELEASE=4 (3-bit)
  - ENV_MAX function of ENVSIZE
- Sub-module env_scaler: the 2-stage signed×unsigned multiply/shift pipeline, parameterised by BITSIZE and ENVSIZE, with lrclk and resetn.
- adsr_envelope holds the FSM and env arithmetic and instantiates env_scaler.

Test Plan:
- Reset mid-ATTACK with env=0x3000, resetn low -> env=0, out=0, active=0 immediately (asynchronous); after release, state stays IDLE until a gate rising edge.
- Attack from reset: attack_rate=0x1000, gate rises -> env steps 0x1000..0xF000 over 15 samples, 16th sample saturates to 0xFFFF, then state DECAY.
- Decay to sustain: env=0xFFFF, decay_rate=0x4000, sustain_level=0x8000 -> env 0xBFFF, then 0x8000 with state SUSTAIN; changing sustain_level to 0x6000 -> env=0x6000 next sample.
- Release and retrigger: SUSTAIN at 0x6000, gate low, release_rate=0x2000 -> RELEASE, env 0x4000, 0x2000, 0 and IDLE, active=0; gate re-raised at env=0x2000 -> ATTACK from 0x2000.
- Scaling and latency: env=0xFFFF held, in=0x7FFFFF -> out=0x7FFF7F exactly 2 samples later; in=0x800000 -> out=0x800080; env=0x8000, in=0x000003 -> out=0x000001; in=-3 -> out=-2 (floor).
- Zero rate: attack_rate=0 with gate high -> env held at current value, state stays ATTACK indefinitely; gate low -> RELEASE next sample.
